down_counter_4b_cload: RTL

//   Parameterised down counter with a synchronous constant load. It is the

---
 rtl/down_counter_4b_cload_if.sv | 30 +++
 rtl/down_counter_4b_cload.sv | 64 ++++++
 2 files changed

// File: rtl/down_counter_4b_cload_if.sv
// Bundles the counter's control inputs and status outputs.
// The timer drives the slave side; the surrounding control logic drives the master side.
interface down_counter_4b_cload_if #(
   parameter int WIDTH = 4
);
   logic             load;
   logic             en;
   logic [WIDTH-1:0] q;
   logic             zero;
   logic             tc;
   logic             done;

   modport master (
      output load,
      output en,
      input  q,
      input  zero,
      input  tc,
      input  done
   );

   modport slave (
      input  load,
      input  en,
      output q,
      output zero,
      output tc,
      output done
   );
endinterface

// File: rtl/down_counter_4b_cload.sv
// Down counter with synchronous constant load, used as an interval/timeout timer.
// At zero it can wrap, reload, or stop and raise a sticky expired flag.
module down_counter_4b_cload #(
   parameter int               WIDTH    = 4,
   parameter logic [WIDTH-1:0] LOAD_VAL = WIDTH'(9),
   parameter int               MODE     = 0
) (
   input logic                    clk,
   input logic                    rst,
   down_counter_4b_cload_if.slave bus
);
   typedef enum logic {
      RUN     = 1'b0,
      EXPIRED = 1'b1
   } state_t;

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] q_next;
   logic             tc_reg;
   logic             tc_next;
   state_t           state_reg;
   state_t           state_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_reg     <= '0;
         tc_reg    <= 1'b0;
         state_reg <= RUN;
      end else begin
         q_reg     <= q_next;
         tc_reg    <= tc_next;
         state_reg <= state_next;
      end
   end

   // tc only fires on a decrement from 1, so loads and parking at zero never pulse it.
   always_comb begin
      q_next     = q_reg;
      tc_next    = 1'b0;
      state_next = state_reg;
      if (bus.load) begin
         q_next     = LOAD_VAL;
         state_next = RUN;
      end else if (bus.en) begin
         if (q_reg != '0) begin
            q_next  = q_reg - ONE;
            tc_next = (q_reg == ONE);
         end else if (MODE == 1) begin
            q_next = LOAD_VAL;
         end else if (MODE == 2) begin
            state_next = EXPIRED;
         end else begin
            q_next = '1;
         end
      end
   end

   assign bus.q    = q_reg;
   assign bus.zero = (q_reg == '0);
   assign bus.tc   = tc_reg;
   assign bus.done = (MODE == 2) && (state_reg == EXPIRED);
endmodule
